// File: rtl/spi_flash_emu_pkg.sv
// Shared types and constants for the SPI NOR flash emulator: opcodes,
// controller states, data-phase modes and the opcode decoder.
package spi_flash_emu_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_FAST = 8'h0B;
  localparam logic [7:0] OP_DUAL = 8'h3B;
  localparam logic [7:0] OP_QUAD = 8'h6B;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_DUAL,
    MODE_QUAD
  } data_mode_t;

  typedef struct packed {
    logic       valid;
    logic       dummy;
    data_mode_t mode;
  } cmd_t;

  // Quad read only exists when the build enables it; otherwise it decodes as unknown.
  function automatic cmd_t decode_op(input logic [7:0] op, input logic quad_en);
    cmd_t c;
    c.valid = 1'b1;
    c.dummy = 1'b1;
    c.mode  = MODE_SINGLE;
    case (op)
      OP_READ: c.dummy = 1'b0;
      OP_FAST: c.mode  = MODE_SINGLE;
      OP_DUAL: c.mode  = MODE_DUAL;
      OP_QUAD: begin
        if (quad_en) c.mode  = MODE_QUAD;
        else         c.valid = 1'b0;
      end
      default: c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_flash_emu_sync.sv
// Two-flop synchronisers for the SPI pins plus single-clk sck edge pulses
// derived from the synchronised clock.
module spi_flash_emu_sync (
  input  logic       clk,
  input  logic       resetb,
  input  logic       i_csb,
  input  logic       i_sck,
  input  logic [3:0] i_io,
  output logic       o_csb,
  output logic [3:0] o_io,
  output logic       o_sck_rise,
  output logic       o_sck_fall
);

  logic [1:0] r_csb_q;
  logic [2:0] r_sck_q;
  logic [3:0] r_io_m;
  logic [3:0] r_io_s;

  // Chip select resets to the deselected level so busy is low out of reset.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_csb_q <= 2'b11;
      r_sck_q <= '0;
      r_io_m  <= '0;
      r_io_s  <= '0;
    end else begin
      r_csb_q <= {r_csb_q[0], i_csb};
      r_sck_q <= {r_sck_q[1:0], i_sck};
      r_io_m  <= i_io;
      r_io_s  <= r_io_m;
    end
  end

  assign o_csb      = r_csb_q[1];
  assign o_io       = r_io_s;
  assign o_sck_rise = r_sck_q[1] & ~r_sck_q[2];
  assign o_sck_fall = ~r_sck_q[1] & r_sck_q[2];

endmodule

// File: rtl/spi_flash_emu.sv
// Read-only SPI NOR flash emulator (0x03/0x0B/0x3B/0x6B) backed by an on-chip
// byte array that is preloaded through a parallel port while deselected.
module spi_flash_emu
  import spi_flash_emu_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int DUMMY_CYCLES = 8,
  parameter int QUAD_EN      = 1
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              csb,
  input  logic              sck,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy
);

  localparam int CNT_W = 6;

  logic        w_csb;
  logic        w_rise;
  logic        w_fall;
  logic [3:0]  w_io;
  logic [2:0]  w_unused_io;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [6:0]        r_cmd_sh;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_inc;
  data_mode_t  r_mode;
  logic        r_dummy;
  logic [2:0]  r_step;
  logic [7:0]  r_byte_sh;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_mem [DEPTH];

  cmd_t        w_cmd;
  logic        w_cmd_done;
  logic        w_addr_done;
  logic        w_dummy_done;
  logic [7:0]  w_byte;
  logic [7:0]  w_byte_nxt;
  logic [3:0]  w_out;
  logic [3:0]  w_oe;
  logic        w_last;

  spi_flash_emu_sync u_sync (
    .clk        (clk),
    .resetb     (resetb),
    .i_csb      (csb),
    .i_sck      (sck),
    .i_io       (io_in),
    .o_csb      (w_csb),
    .o_io       (w_io),
    .o_sck_rise (w_rise),
    .o_sck_fall (w_fall)
  );

  assign w_unused_io  = w_io[3:1];
  assign busy         = ~w_csb;
  assign w_cmd        = decode_op({r_cmd_sh, w_io[0]}, QUAD_EN != 0);
  assign w_cmd_done   = w_rise && (r_bit_cnt == CNT_W'(CMD_BITS - 1));
  assign w_addr_done  = w_rise && (r_bit_cnt == CNT_W'(ADDR_BITS - 1));
  assign w_dummy_done = w_rise && (r_bit_cnt == CNT_W'(DUMMY_CYCLES - 1));
  // Wrap at the last populated byte, not at the end of the address space.
  assign w_addr_inc   = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (w_csb) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = CMD;
        CMD:   if (w_cmd_done) w_state_nxt = w_cmd.valid ? ADDR : IGNORE;
        ADDR:  if (w_addr_done)
                 w_state_nxt = (r_dummy && DUMMY_CYCLES != 0) ? DUMMY : DATA;
        DUMMY: if (w_dummy_done) w_state_nxt = DATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Lane mapping for one sck fall; step 0 of each byte takes the prefetched byte.
  always_comb begin
    w_byte     = (r_step == 3'd0) ? r_rd_data : r_byte_sh;
    w_out      = '0;
    w_oe       = '0;
    w_byte_nxt = w_byte;
    w_last     = 1'b0;
    case (r_mode)
      MODE_DUAL: begin
        w_out      = {2'b00, w_byte[7:6]};
        w_oe       = 4'b0011;
        w_byte_nxt = {w_byte[5:0], 2'b00};
        w_last     = (r_step == 3'd3);
      end
      MODE_QUAD: begin
        w_out      = w_byte[7:4];
        w_oe       = 4'b1111;
        w_byte_nxt = {w_byte[3:0], 4'b0000};
        w_last     = (r_step == 3'd1);
      end
      default: begin
        w_out      = {2'b00, w_byte[7], 1'b0};
        w_oe       = 4'b0010;
        w_byte_nxt = {w_byte[6:0], 1'b0};
        w_last     = (r_step == 3'd7);
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_bit_cnt <= '0;
      r_cmd_sh  <= '0;
      r_addr    <= '0;
      r_mode    <= MODE_SINGLE;
      r_dummy   <= 1'b0;
      r_step    <= '0;
      r_byte_sh <= '0;
      io_out    <= '0;
      io_oe     <= '0;
    end else if (w_csb) begin
      r_bit_cnt <= '0;
      r_cmd_sh  <= '0;
      r_step    <= '0;
      io_out    <= '0;
      io_oe     <= '0;
    end else begin
      case (r_state)
        CMD: if (w_rise) begin
          r_cmd_sh  <= {r_cmd_sh[5:0], w_io[0]};
          r_bit_cnt <= w_cmd_done ? '0 : r_bit_cnt + 1'b1;
          if (w_cmd_done) begin
            r_mode  <= w_cmd.mode;
            r_dummy <= w_cmd.dummy;
          end
        end
        // Only the low ADDR_W address bits survive the shift.
        ADDR: if (w_rise) begin
          r_addr    <= {r_addr[ADDR_W-2:0], w_io[0]};
          r_bit_cnt <= w_addr_done ? '0 : r_bit_cnt + 1'b1;
        end
        DUMMY: if (w_rise) begin
          r_bit_cnt <= w_dummy_done ? '0 : r_bit_cnt + 1'b1;
        end
        DATA: if (w_fall) begin
          io_out    <= w_out;
          io_oe     <= w_oe;
          r_byte_sh <= w_byte_nxt;
          r_step    <= w_last ? '0 : r_step + 1'b1;
          if (w_last) r_addr <= w_addr_inc;
        end
        default: ;
      endcase
    end
  end

  // Preload is locked out while selected; the read port prefetches every clk.
  // NOTE: the storage array has no reset so it maps onto block RAM and survives resetb.
  always_ff @(posedge clk) begin
    if (load_we && !busy && (32'(load_addr) < DEPTH)) r_mem[load_addr] <= load_data;
    r_rd_data <= r_mem[r_addr];
  end

endmodule

// File: tb/tb_spi_flash_emu.sv
// Directed bench for spi_flash_emu: bit-banged SPI master, expected bytes
// queued as each read is issued and compared as the data phase is sampled.
module tb_spi_flash_emu;
  import spi_flash_emu_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int DUMMY  = 8;
  localparam int HALF   = 80;

  logic              clk = 1'b0;
  logic              resetb;
  logic              csb;
  logic              sck;
  logic [3:0]        io_in;
  logic [3:0]        io_out, io_oe, io_out_nq, io_oe_nq;
  logic              busy, busy_nq;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] s_out, s_oe, oe_acc, nq_oe_acc;

  always #5 clk = ~clk;

  spi_flash_emu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DUMMY_CYCLES(DUMMY), .QUAD_EN(1)) dut (
    .clk(clk), .resetb(resetb), .csb(csb), .sck(sck), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy(busy)
  );

  spi_flash_emu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DUMMY_CYCLES(DUMMY), .QUAD_EN(0)) dut_nq (
    .clk(clk), .resetb(resetb), .csb(csb), .sck(sck), .io_in(io_in),
    .io_out(io_out_nq), .io_oe(io_oe_nq), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .busy(busy_nq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_addr = a;
    load_data = d;
    load_we   = 1'b1;
    #10;
    load_we   = 1'b0;
    #10;
  endtask

  // One sck period; outputs are sampled late in the low phase, before the rise.
  task automatic sck_cycle(input logic mosi);
    io_in = {3'b000, mosi};
    #(HALF);
    s_out     = io_out;
    s_oe      = io_oe;
    oe_acc    = oe_acc | io_oe;
    nq_oe_acc = nq_oe_acc | io_oe_nq;
    sck = 1'b1;
    #(HALF);
    sck = 1'b0;
  endtask

  task automatic cs_low();
    csb = 1'b0;
    #(HALF);
  endtask

  task automatic cs_high();
    csb = 1'b1;
    #(2 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sck_cycle(b[i]);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = 23; i >= 24 - n; i--) sck_cycle(v[i]);
  endtask

  task automatic read_bytes(input int n, input data_mode_t mode, input logic [3:0] exp_oe);
    logic [7:0] got;
    logic [7:0] exp;
    int         steps;
    steps = (mode == MODE_QUAD) ? 2 : (mode == MODE_DUAL) ? 4 : 8;
    for (int b = 0; b < n; b++) begin
      got = '0;
      for (int s = 0; s < steps; s++) begin
        sck_cycle(1'b0);
        if (s == 0) check("data_oe", 32'(s_oe), 32'(exp_oe));
        case (mode)
          MODE_QUAD: got = {got[3:0], s_out};
          MODE_DUAL: got = {got[5:0], s_out[1:0]};
          default:   got = {got[6:0], s_out[1]};
        endcase
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL scoreboard_empty: observed %0h expected none", got);
      end else begin
        exp = exp_q.pop_front();
        check("data_byte", 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic read_txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes,
                          input data_mode_t mode, input logic [3:0] exp_oe, input bit dummy);
    cs_low();
    send_byte(op);
    send_bits(addr, 24);
    if (dummy) begin
      oe_acc = '0;
      repeat (DUMMY) sck_cycle(1'b0);
      check("dummy_oe_quiet", 32'(oe_acc), 32'h0);
    end
    read_bytes(nbytes, mode, exp_oe);
    cs_high();
    check("oe_after_csb", 32'(io_oe), 32'h0);
  endtask

  initial begin
    resetb    = 1'b0;
    csb       = 1'b1;
    sck       = 1'b0;
    io_in     = '0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    oe_acc    = '0;
    nq_oe_acc = '0;
    #2;
    repeat (3) @(posedge clk);
    #2;
    resetb = 1'b1;
    #20;

    check("reset_io_out", 32'(io_out), 32'h0);
    check("reset_io_oe", 32'(io_oe), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_busy_nq", 32'(busy_nq), 32'h0);

    load(10'h010, 8'hA5);
    load(10'h011, 8'h5A);
    load(10'h020, 8'h3C);
    load(10'h021, 8'hF0);
    load(10'(DEPTH - 1), 8'h11);
    load(10'h000, 8'h22);

    // Single read, two bytes
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    read_txn(OP_READ, 24'h000010, 2, MODE_SINGLE, 4'b0010, 1'b0);
    check("busy_idle", 32'(busy), 32'h0);

    // Fast read: data only after the dummy cycles
    exp_q.push_back(8'hA5);
    read_txn(OP_FAST, 24'h000010, 1, MODE_SINGLE, 4'b0010, 1'b1);

    // Dual read
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    read_txn(OP_DUAL, 24'h000010, 2, MODE_DUAL, 4'b0011, 1'b1);

    // Quad read; the QUAD_EN=0 instance must never enable a pad
    nq_oe_acc = '0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hF0);
    read_txn(OP_QUAD, 24'h000020, 2, MODE_QUAD, 4'b1111, 1'b1);
    check("quad_disabled_oe", 32'(nq_oe_acc), 32'h0);
    check("quad_disabled_out", 32'(io_out_nq), 32'h0);

    // Wrap from DEPTH-1 to 0; upper SPI address bits are ignored
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    read_txn(OP_READ, 24'hFC03FF, 2, MODE_SINGLE, 4'b0010, 1'b0);

    // Abort after 12 address bits, then a fresh read
    cs_low();
    send_byte(OP_READ);
    send_bits(24'h000010, 12);
    cs_high();
    check("abort_oe", 32'(io_oe), 32'h0);
    exp_q.push_back(8'hA5);
    read_txn(OP_READ, 24'h000010, 1, MODE_SINGLE, 4'b0010, 1'b0);

    // Unknown opcode keeps the pads released
    cs_low();
    send_byte(8'h9F);
    oe_acc = '0;
    repeat (32) sck_cycle(1'b1);
    check("unknown_op_oe", 32'(oe_acc), 32'h0);
    cs_high();

    // Reset in the middle of the data phase
    cs_low();
    send_byte(OP_READ);
    send_bits(24'h000010, 24);
    exp_q.push_back(8'hA5);
    read_bytes(1, MODE_SINGLE, 4'b0010);
    repeat (4) sck_cycle(1'b0);
    check("pre_reset_oe", 32'(io_oe), 32'h2);
    resetb = 1'b0;
    #1;
    check("async_reset_oe", 32'(io_oe), 32'h0);
    check("async_reset_out", 32'(io_out), 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
    csb = 1'b1;
    #20;
    resetb = 1'b1;
    #(HALF);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    read_txn(OP_READ, 24'h000010, 2, MODE_SINGLE, 4'b0010, 1'b0);

    // Preload writes are dropped while selected
    cs_low();
    check("busy_selected", 32'(busy), 32'h1);
    load(10'h010, 8'hFF);
    cs_high();
    exp_q.push_back(8'hA5);
    read_txn(OP_READ, 24'h000010, 1, MODE_SINGLE, 4'b0010, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
